mem_subsystem_param: RTL
========================

Name: mem_subsystem_param

Overview:
Parametrised memory subsystem for the team microprocessor. It provides a synchronous instruction ROM with a program-load write port, and a data RAM behind a req/ack handshake with configurable wait states. It also provides a memory-mapped I/O window of output and input registers, plus bus-error reporting. The subsystem sits between the CPU core and the instruction/data buses.

Parameters:
DATA_W, 8, data bus width in bits
INSTR_W, 9, instruction word width in bits
ADDR_W, 8, address width of both buses
DEPTH, 240, implemented words in data RAM and in instruction memory; DEPTH <= IO_BASE
WAIT_STATES, 1, extra cycles inserted before Data_Ack; 0..15
IO_BASE, 240, first data address of the I/O window
N_IO, 4, number of output registers and number of input ports in the I/O window

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-high reset
Fetch_Req  in  1  instruction fetch request
Address_Instruction_Bus  in  ADDR_W  fetch address
Instruction  out  INSTR_W  fetched word
Instr_Valid  out  1  Instruction is valid this cycle
Prog_We  in  1  program-load write strobe
Prog_Addr  in  ADDR_W  program-load address
Prog_Data  in  INSTR_W  program-load word
Data_Req  in  1  data access request
LE  in  1  1 = write, 0 = read; sampled with Data_Req
Address_Data_Bus  in  ADDR_W  data address
DataOut_Bus  in  DATA_W  write data from CPU
DataIn_Bus  out  DATA_W  read data to CPU
Data_Ack  out  1  one-cycle completion pulse
Busy  out  1  data FSM not IDLE
Bus_Err  out  1  pulses with Data_Ack on an unmapped access
Io_Out  out  N_IO*DATA_W  output registers; register k occupies bits [k*DATA_W +: DATA_W]
Io_In  in  N_IO*DATA_W  asynchronous input ports

Behaviour:
- Reset (async, Rst=1): Instruction=0, Instr_Valid=0, DataIn_Bus=0, Data_Ack=0, Busy=0, Bus_Err=0, Io_Out=0, FSM=IDLE, wait counter=0, Io_In synchronisers=0. Memory contents are not cleared.
- Reset mid-transaction: the transaction is aborted and no RAM or Io_Out write occurs.
- Fetch path, 1-cycle latency:
  - Fetch_Req in cycle n gives Instruction and Instr_Valid=1 in cycle n+1.
  - An address >= DEPTH returns 0 with Instr_Valid=1.
- Program-load priority: Prog_We writes Prog_Data at Prog_Addr (ignored if >= DEPTH). When Prog_We and Fetch_Req are both high, the write wins and Instr_Valid=0 the next cycle. The fetch is dropped and must be re-issued.
- Data FSM states: IDLE, WAIT, RESP.
  - IDLE: on Data_Req=1, capture address, LE and DataOut_Bus. Go to WAIT if WAIT_STATES>0, else RESP. Busy=1 from the next cycle.
  - WAIT: the counter loads WAIT_STATES-1 and decrements to 0, then goes to RESP. Inputs are ignored.
  - RESP: Data_Ack=1 for exactly one cycle, then go to IDLE.
    - Read: DataIn_Bus is valid in the Data_Ack cycle and holds until the next read completes.
    - Write: commits on the RESP clock edge.
- Latency: Data_Req accepted at edge n gives Data_Ack in cycle n+1+WAIT_STATES.
- Back-to-back: a request held high is accepted in the cycle after Data_Ack. Throughput is one access per WAIT_STATES+2 cycles.
- Address decode on the captured address:
  - addr < DEPTH: RAM.
  - IO_BASE <= addr < IO_BASE+N_IO: I/O window.
    - Write: updates output register addr-IO_BASE.
    - Read: returns the 2-flop-synchronised Io_In[addr-IO_BASE].
  - Anything else: Bus_Err=1 in the Data_Ack cycle, read data=0, write discarded.
- Simultaneous fetch and data access: the two paths are independent ports and have no interaction.

Decomposition:
- Shared package mem_subsystem_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), region decode constants (REG_RAM, REG_IO, REG_ERR), and the WAIT_STATES range limit.
- One sub-module: io_window_regs (N_IO output registers, 2-flop input synchroniser, indexed read mux).
- The RAM arrays are inferred inline.

Test Plan:
- Reset: assert Rst mid-WAIT of a write (addr 8'h10, data 8'hA5) -> all outputs 0 and a later read of 8'h10 does not return 8'hA5.
- Program load then fetch: Prog_We at addr 3 with 9'h1C7, then Fetch_Req addr 3 -> Instr_Valid=1 and Instruction=9'h1C7 one cycle later. Prog_We and Fetch_Req together -> Instr_Valid=0.
- RAM timing, WAIT_STATES=1: write 8'h5A to 8'h20, then read 8'h20 -> each Data_Ack arrives 2 cycles after acceptance and DataIn_Bus=8'h5A. Repeat with WAIT_STATES=0 -> Data_Ack after 1 cycle.
- I/O window: write 8'h3C to 8'hF2 -> Io_Out[23:16]=8'h3C. Drive Io_In[7:0]=8'h81 and read 8'hF0 -> 8'h81.
- Bus error: read 8'hF8 with N_IO=4 -> Bus_Err=1 with Data_Ack and DataIn_Bus=0. Write 8'hFF to 8'hFC -> no Io_Out or RAM change.
- Back-to-back: hold Data_Req high for 3 reads at addresses 0,1,2 -> Data_Ack pulses spaced WAIT_STATES+2 cycles apart, with correct data each time.

Source files
------------

// File: rtl/mem_subsystem_pkg.sv
// Shared definitions for the memory subsystem: data-FSM encoding, region
// decode and the wait-state counter sizing.
package mem_subsystem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } data_state_e;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_IO  = 2'd1,
    REG_ERR = 2'd2
  } region_e;

  localparam int MAX_WAIT_STATES = 15;
  localparam int WAIT_CNT_W      = 4;

  // RAM wins over the I/O window; anything outside both is a bus error.
  function automatic region_e decode_region(input int addr, input int depth,
                                            input int io_base, input int n_io);
    region_e r;
    if (addr < depth) begin
      r = REG_RAM;
    end else if ((addr >= io_base) && (addr < io_base + n_io)) begin
      r = REG_IO;
    end else begin
      r = REG_ERR;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_window_regs.sv
// Memory-mapped I/O window: output registers, 2-flop input synchronisers
// and the indexed read mux.
module io_window_regs #(
  parameter int DATA_W = 8,
  parameter int N_IO   = 4,
  parameter int IDX_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_IO*DATA_W-1:0]   io_in,
  output logic [DATA_W-1:0]        rd_data,
  output logic [N_IO*DATA_W-1:0]   io_out
);

  logic [N_IO*DATA_W-1:0] out_r;
  logic [N_IO*DATA_W-1:0] sync1_r;
  logic [N_IO*DATA_W-1:0] sync2_r;
  logic [DATA_W-1:0]      rd_data_s;

  // Output registers and input synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r   <= '0;
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= io_in;
      sync2_r <= sync1_r;
      for (int k = 0; k < N_IO; k++) begin
        if (wr_en && (idx == IDX_W'(k))) begin
          out_r[k*DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

  // AND-OR read mux over the synchronised ports.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < N_IO; k++) begin
      rd_data_s = rd_data_s |
                  ({DATA_W{idx == IDX_W'(k)}} & sync2_r[k*DATA_W +: DATA_W]);
    end
  end

  assign rd_data = rd_data_s;
  assign io_out  = out_r;

endmodule

// File: rtl/mem_subsystem_param.sv
// Instruction ROM with program-load port, plus a wait-stated data RAM and
// I/O window behind a req/ack handshake with bus-error reporting.
module mem_subsystem_param
  import mem_subsystem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int INSTR_W     = 9,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 240,
  parameter int WAIT_STATES = 1,
  parameter int IO_BASE     = 240,
  parameter int N_IO        = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Fetch_Req,
  input  logic [ADDR_W-1:0]      Address_Instruction_Bus,
  output logic [INSTR_W-1:0]     Instruction,
  output logic                   Instr_Valid,
  input  logic                   Prog_We,
  input  logic [ADDR_W-1:0]      Prog_Addr,
  input  logic [INSTR_W-1:0]     Prog_Data,
  input  logic                   Data_Req,
  input  logic                   LE,
  input  logic [ADDR_W-1:0]      Address_Data_Bus,
  input  logic [DATA_W-1:0]      DataOut_Bus,
  output logic [DATA_W-1:0]      DataIn_Bus,
  output logic                   Data_Ack,
  output logic                   Busy,
  output logic                   Bus_Err,
  output logic [N_IO*DATA_W-1:0] Io_Out,
  input  logic [N_IO*DATA_W-1:0] Io_In
);

  localparam int IDX_W = (N_IO > 1) ? $clog2(N_IO) : 1;
  localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  logic [INSTR_W-1:0] imem_r [DEPTH];
  logic [DATA_W-1:0]  dmem_r [DEPTH];

  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               prog_in_s;
  logic               fetch_in_s;

  data_state_e            state_r, state_nx_s;
  logic [WAIT_CNT_W-1:0]  wait_cnt_r, wait_cnt_nx_s;
  logic                   capture_s;
  logic [ADDR_W-1:0]      addr_r;
  logic                   le_r;
  logic [DATA_W-1:0]      wdata_r;
  logic [ADDR_W-1:0]      acc_addr_s;
  logic                   acc_le_s;
  region_e                acc_region_s;
  logic                   enter_resp_s;
  logic                   commit_s;
  logic [IDX_W-1:0]       io_idx_s;
  logic [DATA_W-1:0]      io_rd_s;
  logic [DATA_W-1:0]      rd_val_s;
  logic [DATA_W-1:0]      rdata_r;
  logic                   ack_r, busy_r, err_r;

  assign prog_in_s  = int'(Prog_Addr) < DEPTH;
  assign fetch_in_s = int'(Address_Instruction_Bus) < DEPTH;

  // Program-load write port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (Prog_We && prog_in_s) begin
      imem_r[Prog_Addr] <= Prog_Data;
    end
  end

  // Fetch port: a program-load in the same cycle drops the fetch.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      instr_r       <= '0;
      instr_valid_r <= 1'b0;
    end else if (Prog_We) begin
      instr_valid_r <= 1'b0;
    end else if (Fetch_Req) begin
      instr_valid_r <= 1'b1;
      instr_r       <= fetch_in_s ? imem_r[Address_Instruction_Bus] : '0;
    end else begin
      instr_valid_r <= 1'b0;
    end
  end

  // Data FSM next-state and wait counter.
  always_comb begin
    state_nx_s    = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    capture_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Data_Req) begin
          capture_s = 1'b1;
          if (WAIT_STATES > 0) begin
            state_nx_s    = ST_WAIT;
            wait_cnt_nx_s = WS_LOAD;
          end else begin
            state_nx_s = ST_RESP;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == '0) begin
          state_nx_s = ST_RESP;
        end else begin
          wait_cnt_nx_s = wait_cnt_r - 1'b1;
        end
      end
      ST_RESP: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge, so the
  // access fields come straight from the bus while still IDLE.
  assign acc_addr_s   = (state_r == ST_IDLE) ? Address_Data_Bus : addr_r;
  assign acc_le_s     = (state_r == ST_IDLE) ? LE : le_r;
  assign acc_region_s = decode_region(int'(acc_addr_s), DEPTH, IO_BASE, N_IO);
  assign enter_resp_s = (state_nx_s == ST_RESP);
  assign commit_s     = (state_r == ST_RESP) && le_r;
  assign io_idx_s     = IDX_W'(acc_addr_s - ADDR_W'(IO_BASE));

  // Read-data source selection by region.
  always_comb begin
    rd_val_s = '0;
    case (acc_region_s)
      REG_RAM: rd_val_s = dmem_r[acc_addr_s];
      REG_IO:  rd_val_s = io_rd_s;
      REG_ERR: rd_val_s = '0;
      default: rd_val_s = '0;
    endcase
  end

  // Data FSM state, captured request and registered response outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      addr_r     <= '0;
      le_r       <= 1'b0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      wait_cnt_r <= wait_cnt_nx_s;
      if (capture_s) begin
        addr_r  <= Address_Data_Bus;
        le_r    <= LE;
        wdata_r <= DataOut_Bus;
      end
      if (enter_resp_s && !acc_le_s) begin
        rdata_r <= rd_val_s;
      end
      ack_r  <= enter_resp_s;
      busy_r <= (state_nx_s != ST_IDLE);
      err_r  <= enter_resp_s && (acc_region_s == REG_ERR);
    end
  end

  // Data RAM write commits on the RESP edge only.
  always_ff @(posedge Clk) begin
    if (commit_s && (acc_region_s == REG_RAM)) begin
      dmem_r[addr_r] <= wdata_r;
    end
  end

  io_window_regs #(
    .DATA_W (DATA_W),
    .N_IO   (N_IO),
    .IDX_W  (IDX_W)
  ) u_io (
    .clk     (Clk),
    .rst     (Rst),
    .wr_en   (commit_s && (acc_region_s == REG_IO)),
    .idx     (io_idx_s),
    .wr_data (wdata_r),
    .io_in   (Io_In),
    .rd_data (io_rd_s),
    .io_out  (Io_Out)
  );

  assign Instruction = instr_r;
  assign Instr_Valid = instr_valid_r;
  assign DataIn_Bus  = rdata_r;
  assign Data_Ack    = ack_r;
  assign Busy        = busy_r;
  assign Bus_Err     = err_r;

endmodule
